// File: rtl/boot_rom_arbiter.sv
// Round-robin arbiter placing N TCDM-style masters onto the single boot ROM port.
// Writes and out-of-range reads are answered locally with an error and never reach the ROM.
module boot_rom_arbiter #(
  parameter int unsigned N_MASTERS      = 2,
  parameter int unsigned ROM_ADDR_WIDTH = 13,
  parameter logic [31:0] BASE_ADDR      = 32'h1A000000,
  parameter logic [31:0] ERR_RDATA      = 32'hBADACCE5
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_MASTERS-1:0]        m_req_i,
  input  logic [N_MASTERS-1:0][31:0]  m_add_i,
  input  logic [N_MASTERS-1:0]        m_wen_i,
  output logic [N_MASTERS-1:0]        m_gnt_o,
  output logic [N_MASTERS-1:0]        m_r_valid_o,
  output logic [N_MASTERS-1:0][31:0]  m_r_rdata_o,
  output logic [N_MASTERS-1:0]        m_r_opc_o,
  output logic                        rom_req_o,
  output logic [31:0]                 rom_add_o,
  input  logic                        rom_gnt_i,
  input  logic                        rom_r_valid_i,
  input  logic [31:0]                 rom_r_rdata_i
);

  localparam int unsigned PTR_W   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  // 33-bit end bound so a ROM placed at the top of the map cannot wrap
  localparam logic [32:0] ROM_END = {1'b0, BASE_ADDR} + (33'd1 << ROM_ADDR_WIDTH);

  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] owner_q;
  logic             pend_q;
  logic             err_q;

  logic [PTR_W-1:0] cand;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] rr_next;
  logic             found;
  logic [31:0]      win_add;
  logic             win_ok;
  logic             gnt_rom;
  logic             gnt_loc;

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      cand = PTR_W'((32'(rr_ptr_q) + k) % N_MASTERS);
      if (!found && m_req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign win_add = m_add_i[win];
  assign win_ok  = m_wen_i[win]
                   && ({1'b0, win_add} >= {1'b0, BASE_ADDR})
                   && ({1'b0, win_add} < ROM_END);
  assign rr_next = PTR_W'((32'(win) + 32'd1) % N_MASTERS);

  // Gating with rst_ni keeps grants and the ROM request low for the whole reset window
  assign rom_req_o = rst_ni && found && win_ok;
  assign rom_add_o = rom_req_o ? win_add : '0;
  assign gnt_rom   = rom_req_o && rom_gnt_i;
  assign gnt_loc   = rst_ni && found && !win_ok;

  always_comb begin
    m_gnt_o = '0;
    if (gnt_rom || gnt_loc) m_gnt_o[win] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      owner_q  <= '0;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      pend_q <= gnt_rom;
      err_q  <= gnt_loc;
      if (gnt_rom || gnt_loc) begin
        owner_q  <= win;
        rr_ptr_q <= rr_next;
      end
    end
  end

  // Fixed one-cycle ROM latency means a single owner slot covers back-to-back traffic
  always_comb begin
    m_r_valid_o = '0;
    m_r_rdata_o = '0;
    m_r_opc_o   = '0;
    if (pend_q) begin
      m_r_valid_o[owner_q] = rom_r_valid_i;
      m_r_rdata_o[owner_q] = rom_r_rdata_i;
    end else if (err_q) begin
      m_r_valid_o[owner_q] = 1'b1;
      m_r_rdata_o[owner_q] = ERR_RDATA;
      m_r_opc_o[owner_q]   = 1'b1;
    end
  end

endmodule
